uart_word_rx: RTL and testbench

- Oversampling UART receiver front-end for the SoC serial input path.
- Accepts a physical asynchronous rxd line at a fixed baud of CLKS_PER_BIT clocks per bit.
- Validates framing and packs four received bytes into a 32-bit word; the first byte goes to [31:24].
- Buffers words in a small FIFO with a valid/ready handshake toward the RAM-write side.

---
 rtl/uart_word_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_word_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
// uart_word_rx
//   Oversampling 8N1 UART receiver. It packs four bytes into a 32-bit word,
//   with the first byte in [31:24], and queues the words in a small FIFO that
//   uses a valid/ready handshake.
//
// Ports
//   clk         system clock, rising edge
//   nrst        asynchronous active-low reset
//   rxd         asynchronous serial input, idle high, LSB first
//   word_data   FIFO head word (0 when empty)
//   word_valid  FIFO not empty
//   word_ready  consumer accepts the head word this cycle
//   frame_err   sticky: a stop bit was sampled low
//   overflow    sticky: a word was dropped because the FIFO was full
//   err_clr     clears frame_err and overflow (a same-cycle set wins)
//   busy        frame in progress or partial word held
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rxd,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        overflow,
  input  logic        err_clr,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state_reg, state_next;
  logic          rx_meta_reg, rxs_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bitidx_reg;
  logic [7:0]    shreg_reg;
  logic [1:0]    bytecnt_reg;
  logic [23:0]   asm_reg;        // first three bytes of the word being built
  logic          push_reg;
  logic [31:0]   push_data_reg;
  logic          frame_err_reg, overflow_reg;

  logic          shift_en, commit, frame_set;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          pop, full, wr_en, ovf_set;

  // Next-state logic and the per-cycle strobes for the datapath.
  always_comb begin
    state_next = state_reg;
    shift_en   = 1'b0;
    commit     = 1'b0;
    frame_set  = 1'b0;
    case (state_reg)
      IDLE:  if (!rxs_reg) state_next = START;
      START: if (cnt_reg == CNT_MID) state_next = rxs_reg ? IDLE : DATA;
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          shift_en = 1'b1;
          if (bitidx_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          if (rxs_reg) begin
            commit     = 1'b1;
            state_next = IDLE;
          end else begin
            frame_set  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: if (rxs_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_reg   <= 1'b1;
      rxs_reg       <= 1'b1;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bitidx_reg    <= '0;
      shreg_reg     <= '0;
      bytecnt_reg   <= '0;
      asm_reg       <= '0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
    end else begin
      rx_meta_reg <= rxd;
      rxs_reg     <= rx_meta_reg;
      state_reg   <= state_next;
      push_reg    <= 1'b0;

      // The baud counter restarts on every state change. It free-runs only
      // while a frame is being timed.
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (state_reg == START || state_reg == DATA || state_reg == STOP) begin
        cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
      end

      if (state_reg == START) bitidx_reg <= '0;
      if (shift_en) begin
        shreg_reg  <= {rxs_reg, shreg_reg[7:1]};
        bitidx_reg <= bitidx_reg + 3'd1;
      end

      if (commit) begin
        bytecnt_reg <= bytecnt_reg + 2'd1;
        case (bytecnt_reg)
          2'd0: asm_reg[23:16] <= shreg_reg;
          2'd1: asm_reg[15:8]  <= shreg_reg;
          2'd2: asm_reg[7:0]   <= shreg_reg;
          default: begin
            push_reg      <= 1'b1;
            push_data_reg <= {asm_reg, shreg_reg};
          end
        endcase
      end else if (frame_set) begin
        bytecnt_reg <= '0;
      end
    end
  end

  // Word FIFO. A pop in the same cycle as a push while full frees the slot.
  assign pop     = (count_reg != '0) && word_ready;
  assign full    = (count_reg == FULL_CNT);
  assign wr_en   = push_reg && (!full || pop);
  assign ovf_set = push_reg && full && !pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (wr_en && !pop)      count_reg <= count_reg + (PW + 1)'(1);
      else if (!wr_en && pop) count_reg <= count_reg - (PW + 1)'(1);
      frame_err_reg <= frame_set | (frame_err_reg & ~err_clr);
      overflow_reg  <= ovf_set   | (overflow_reg  & ~err_clr);
    end
  end

  // The storage array has no reset. Words that are not valid are masked at
  // the output.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data_reg;
  end

  // The head word is read combinationally so that it is visible in the same
  // cycle that valid is high.
  assign word_valid = (count_reg != '0);
  assign word_data  = word_valid ? mem[rd_ptr_reg] : 32'd0;
  assign frame_err  = frame_err_reg;
  assign overflow   = overflow_reg;
  assign busy       = (state_reg != IDLE) || (bytecnt_reg != 2'd0);

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed testbench for uart_word_rx (CLKS_PER_BIT=8, FIFO_DEPTH=4).
module tb_uart_word_rx;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rxd = 1'b1;
  logic        word_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] word_data;
  logic        word_valid, frame_err, overflow, busy;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] pop_q[$];
  int valid_cycles = 0;

  always #5 clk = ~clk;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .rxd(rxd),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .frame_err(frame_err), .overflow(overflow), .err_clr(err_clr), .busy(busy)
  );

  // Record every handshake (and how many cycles valid is high) on the
  // falling edge, away from the active edge.
  always @(negedge clk) begin
    if (nrst) begin
      if (word_valid) valid_cycles++;
      if (word_valid && word_ready) begin
        pop_q.push_back(word_data);
        $display("pop word %h", word_data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (word_data !== 32'd0) begin n_fail++; $display("FAIL reset_word_data got %h want 0", word_data); end
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    word_ready = 1'b1;
    pop_q.delete();
    valid_cycles = 0;
    send_word(32'hDEADBEEF);
    idle(20);
    n_checks++; if (pop_q.size() != 1) begin n_fail++; $display("FAIL single_pop_count got %0d want 1", pop_q.size()); end
    if (pop_q.size() > 0) begin
      n_checks++; if (pop_q[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_word got %h want deadbeef", pop_q[0]); end
    end
    n_checks++; if (valid_cycles != 1) begin n_fail++; $display("FAIL single_valid_cycles got %0d want 1", valid_cycles); end
    n_checks++; if ({frame_err, overflow} !== 2'b00) begin n_fail++; $display("FAIL single_flags got %b want 00", {frame_err, overflow}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b want 0", busy); end
    $display("test_single_word done");
  endtask

  task automatic test_false_start();
    word_ready = 1'b1;
    pop_q.delete();
    rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(12);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy got %b want 0", busy); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL false_start_frame_err got %b want 0", frame_err); end
    n_checks++; if (pop_q.size() != 0) begin n_fail++; $display("FAIL false_start_pops got %0d want 0", pop_q.size()); end
    send_byte(8'h55, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL false_start_partial_busy got %b want 1", busy); end
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(20);
    n_checks++; if (pop_q.size() != 1) begin n_fail++; $display("FAIL false_start_word_count got %0d want 1", pop_q.size()); end
    if (pop_q.size() > 0) begin
      n_checks++; if (pop_q[0] !== 32'h55112233) begin n_fail++; $display("FAIL false_start_word got %h want 55112233", pop_q[0]); end
    end
    $display("test_false_start done");
  endtask

  task automatic test_frame_err();
    word_ready = 1'b1;
    pop_q.delete();
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b0);
    idle(30);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_set got %b want 1", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_err_busy got %b want 0", busy); end
    n_checks++; if (pop_q.size() != 0) begin n_fail++; $display("FAIL frame_err_pops got %0d want 0", pop_q.size()); end
    send_word(32'h01020304);
    idle(20);
    n_checks++; if (pop_q.size() != 1) begin n_fail++; $display("FAIL frame_err_word_count got %0d want 1", pop_q.size()); end
    if (pop_q.size() > 0) begin
      n_checks++; if (pop_q[0] !== 32'h01020304) begin n_fail++; $display("FAIL frame_err_word got %h want 01020304", pop_q[0]); end
    end
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_sticky got %b want 1", frame_err); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_clear got %b want 0", frame_err); end
    $display("test_frame_err done");
  endtask

  task automatic test_overflow();
    word_ready = 1'b0;
    pop_q.delete();
    for (int w = 1; w <= 5; w++) send_word(32'(w));
    idle(20);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set got %b want 1", overflow); end
    n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL overflow_valid got %b want 1", word_valid); end
    n_checks++; if (word_data !== 32'h1) begin n_fail++; $display("FAIL overflow_head got %h want 00000001", word_data); end
    word_ready = 1'b1;
    idle(10);
    word_ready = 1'b0;
    n_checks++; if (pop_q.size() != 4) begin n_fail++; $display("FAIL overflow_pop_count got %0d want 4", pop_q.size()); end
    for (int i = 0; i < pop_q.size() && i < 4; i++) begin
      n_checks++; if (pop_q[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL overflow_order[%0d] got %h want %h", i, pop_q[i], 32'(i + 1)); end
    end
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_drained got %b want 0", word_valid); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear got %b want 0", overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_full_pop();
    logic [31:0] exp [5];
    exp[0] = 32'hA1A2A3A4; exp[1] = 32'hB1B2B3B4; exp[2] = 32'hC1C2C3C4;
    exp[3] = 32'hD1D2D3D4; exp[4] = 32'hE1E2E3E4;
    word_ready = 1'b0;
    pop_q.delete();
    for (int i = 0; i < 4; i++) send_word(exp[i]);
    send_byte(8'hE1, 1'b1);
    send_byte(8'hE2, 1'b1);
    send_byte(8'hE3, 1'b1);
    // The push of the 4th byte is registered 79 clocks after the start bit
    // begins. Pulse ready for exactly that cycle.
    fork
      send_byte(8'hE4, 1'b1);
      begin
        repeat (79) @(posedge clk);
        #1;
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
      end
    join
    idle(20);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop_overflow got %b want 0", overflow); end
    n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop_valid got %b want 1", word_valid); end
    n_checks++; if (pop_q.size() != 1) begin n_fail++; $display("FAIL full_pop_first_count got %0d want 1", pop_q.size()); end
    word_ready = 1'b1;
    idle(10);
    word_ready = 1'b0;
    n_checks++; if (pop_q.size() != 5) begin n_fail++; $display("FAIL full_pop_total got %0d want 5", pop_q.size()); end
    for (int i = 0; i < pop_q.size() && i < 5; i++) begin
      n_checks++; if (pop_q[i] !== exp[i]) begin n_fail++; $display("FAIL full_pop_order[%0d] got %h want %h", i, pop_q[i], exp[i]); end
    end
    $display("test_full_pop done");
  endtask

  task automatic test_reset_midframe();
    word_ready = 1'b0;
    pop_q.delete();
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    idle(20);
    n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got %b want 1", word_valid); end
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", word_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (word_data !== 32'd0) begin n_fail++; $display("FAIL midrst_word_data got %h want 0", word_data); end
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    idle(30);
    word_ready = 1'b1;
    send_word(32'hCAFEF00D);
    idle(20);
    n_checks++; if (pop_q.size() != 1) begin n_fail++; $display("FAIL midrst_word_count got %0d want 1", pop_q.size()); end
    if (pop_q.size() > 0) begin
      n_checks++; if (pop_q[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midrst_word got %h want cafef00d", pop_q[0]); end
    end
    $display("test_reset_midframe done");
  endtask

  initial begin
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    nrst = 1'b1;
    idle(10);
    test_single_word();
    test_false_start();
    test_frame_err();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
